// File: rtl/space_wire_pkg.sv
// Shared SpaceWire character constants, packet-end test and arbiter state encoding.
package space_wire_pkg;

    localparam logic [8:0] C_EOP = 9'h100;
    localparam logic [8:0] C_EEP = 9'h101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2
    } state_e;

    // EOP and EEP differ only in bit 0; every other control code passes through.
    function automatic logic is_eop_eep(input logic [8:0] ch);
        return ch[8] && (ch[7:1] == 7'd0);
    endfunction

endpackage

// File: rtl/space_wire_rr_select.sv
// Combinational round-robin pick: first valid index after last_idx, wrapping modulo N.
module space_wire_rr_select #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N-1:0]     sel,
    output logic [IDX_W-1:0] sel_idx,
    output logic             any
);

    always_comb begin
        int cand;
        sel     = '0;
        sel_idx = '0;
        any     = 1'b0;
        cand    = 0;
        for (int i = 1; i <= int'(N); i++) begin
            cand = int'(last_idx) + i;
            if (cand >= int'(N)) begin
                cand = cand - int'(N);
            end
            for (int j = 0; j < int'(N); j++) begin
                if (!any && (cand == j) && valid[j]) begin
                    any     = 1'b1;
                    sel[j]  = 1'b1;
                    sel_idx = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/space_wire_tx_fifo_arbiter.sv
// Packet-granular round-robin arbiter for the SpaceWire TX FIFO write port,
// with EEP injection when the owning source stalls mid-packet.
module space_wire_tx_fifo_arbiter
    import space_wire_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned START_LEVEL = 48,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                 i_wr_clk,
    input  logic                 i_reset_n,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [9*N_REQ-1:0]   i_req_data,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic                 o_fifo_wren,
    output logic [8:0]           o_fifo_data,
    input  logic                 i_fifo_full,
    input  logic [5:0]           i_fifo_wrusdw,
    output logic [N_REQ-1:0]     o_grant,
    output logic                 o_busy,
    output logic                 o_abort,
    output logic [7:0]           o_abort_cnt
);

    localparam int unsigned      IDX_W     = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(N_REQ - 1);
    localparam logic [15:0]      TIMEOUT_V = 16'(TIMEOUT);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [15:0]        idle_q, idle_d;
    logic               wren_q, wren_d;
    logic [8:0]         data_q, data_d;
    logic               abort_q, abort_d;
    logic [7:0]         abort_cnt_q, abort_cnt_d;
    logic [N_REQ-1:0]   ready_c;

    logic [N_REQ-1:0]   rr_sel;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_any;
    logic               owner_valid;
    logic [8:0]         owner_char;
    logic               level_ok;

    space_wire_rr_select #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .valid    (i_req_valid),
        .last_idx (last_q),
        .sel      (rr_sel),
        .sel_idx  (rr_idx),
        .any      (rr_any)
    );

    // Owner's valid and character, muxed by the registered owner index.
    always_comb begin
        owner_valid = 1'b0;
        owner_char  = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (owner_q == IDX_W'(k)) begin
                owner_valid = i_req_valid[k];
                owner_char  = i_req_data[9*k +: 9];
            end
        end
    end

    assign level_ok = 32'(i_fifo_wrusdw) < START_LEVEL;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        last_d      = last_q;
        idle_d      = idle_q;
        wren_d      = 1'b0;
        data_d      = data_q;
        abort_d     = 1'b0;
        abort_cnt_d = abort_cnt_q;
        ready_c     = '0;

        case (state_q)
            IDLE: begin
                if (rr_any && !i_fifo_full && level_ok) begin
                    grant_d = rr_sel;
                    owner_d = rr_idx;
                    idle_d  = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (idle_q == TIMEOUT_V) begin
                    state_d = ABORT;
                end else begin
                    ready_c = grant_q & {N_REQ{~i_fifo_full}};
                    if (!i_fifo_full) begin
                        if (owner_valid) begin
                            wren_d = 1'b1;
                            data_d = owner_char;
                            idle_d = '0;
                            if (is_eop_eep(owner_char)) begin
                                last_d  = owner_q;
                                grant_d = '0;
                                state_d = IDLE;
                            end
                        end else begin
                            idle_d = idle_q + 16'd1;
                        end
                    end
                end
            end
            ABORT: begin
                // A full FIFO only delays the EEP; the abort itself is committed.
                if (!i_fifo_full) begin
                    wren_d  = 1'b1;
                    data_d  = C_EEP;
                    abort_d = 1'b1;
                    if (abort_cnt_q != 8'hFF) begin
                        abort_cnt_d = abort_cnt_q + 8'd1;
                    end
                    last_d  = owner_q;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_wr_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            last_q      <= LAST_RST;
            idle_q      <= '0;
            wren_q      <= 1'b0;
            data_q      <= '0;
            abort_q     <= 1'b0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            idle_q      <= idle_d;
            wren_q      <= wren_d;
            data_q      <= data_d;
            abort_q     <= abort_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign o_req_ready = ready_c;
    assign o_fifo_wren = wren_q;
    assign o_fifo_data = data_q;
    assign o_grant     = grant_q;
    assign o_busy      = (state_q != IDLE);
    assign o_abort     = abort_q;
    assign o_abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_space_wire_tx_fifo_arbiter.sv
// Bench for space_wire_tx_fifo_arbiter: queue-fed sources, cycle model checked at every negedge.
module tb_space_wire_tx_fifo_arbiter;

    localparam int N     = 4;
    localparam int TMO   = 10;
    localparam int START = 48;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     vld;
    logic [8:0]       dat [N];
    logic [9*N-1:0]   req_data;
    logic             full;
    logic [5:0]       lvl;
    logic [N-1:0]     o_req_ready;
    logic             o_fifo_wren;
    logic [8:0]       o_fifo_data;
    logic [N-1:0]     o_grant;
    logic             o_busy;
    logic             o_abort;
    logic [7:0]       o_abort_cnt;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_data[9*g +: 9] = dat[g];
    end

    space_wire_tx_fifo_arbiter #(
        .N_REQ       (N),
        .START_LEVEL (START),
        .TIMEOUT     (TMO)
    ) dut (
        .i_wr_clk      (clk),
        .i_reset_n     (rst_n),
        .i_req_valid   (vld),
        .i_req_data    (req_data),
        .o_req_ready   (o_req_ready),
        .o_fifo_wren   (o_fifo_wren),
        .o_fifo_data   (o_fifo_data),
        .i_fifo_full   (full),
        .i_fifo_wrusdw (lvl),
        .o_grant       (o_grant),
        .o_busy        (o_busy),
        .o_abort       (o_abort),
        .o_abort_cnt   (o_abort_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Source side: per-requester character queues and stimulus knobs.
    logic [8:0] src [N][$];
    bit         hold [N];
    int         gap_pct = 0;
    int         full_pct = 0;
    bit         force_full = 0;
    bit         rand_lvl = 0;
    logic [5:0] lvl_set = '0;
    logic [N-1:0] hs_pend = '0;

    // Model state.
    int         m_state;     // 0 idle, 1 owner streaming, 2 abort pending
    int         m_owner;
    int         m_last;
    int         m_idle;
    int         m_abort_cnt;
    bit         e_wren;
    bit         e_abort;
    logic [8:0] e_data;

    // Logs for hand-computed checks.
    logic [8:0] wr_log [$];
    int         wr_cyc [$];
    int         grant_log [$];
    int         abort_pulses;
    logic [N-1:0] prev_grant;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_state     = 0;
        m_owner     = 0;
        m_last      = N - 1;
        m_idle      = 0;
        m_abort_cnt = 0;
        e_wren      = 0;
        e_abort     = 0;
        e_data      = '0;
    endtask

    // One clock of the arbiter's rules, applied to the inputs about to be sampled.
    task automatic m_step();
        logic [8:0] ch;
        e_wren  = 0;
        e_abort = 0;
        if (m_state == 0) begin
            if (vld != '0 && !full && int'(lvl) < START) begin
                for (int off = N; off >= 1; off--) begin
                    if (vld[(m_last + off) % N]) m_owner = (m_last + off) % N;
                end
                m_idle  = 0;
                m_state = 1;
            end
        end else if (m_state == 1) begin
            if (m_idle == TMO) begin
                m_state = 2;
            end else if (!full) begin
                if (vld[m_owner]) begin
                    ch     = dat[m_owner];
                    e_wren = 1;
                    e_data = ch;
                    m_idle = 0;
                    if (ch == 9'h100 || ch == 9'h101) begin
                        m_last  = m_owner;
                        m_state = 0;
                    end
                end else begin
                    m_idle++;
                end
            end
        end else begin
            if (!full) begin
                e_wren  = 1;
                e_data  = 9'h101;
                e_abort = 1;
                if (m_abort_cnt < 255) m_abort_cnt++;
                m_last  = m_owner;
                m_state = 0;
            end
        end
    endtask

    // Source driver: pop on handshake, then present the next character.
    always begin
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (hs_pend[k] && src[k].size() > 0) void'(src[k].pop_front());
        end
        for (int k = 0; k < N; k++) begin
            vld[k] = (src[k].size() > 0) && !hold[k] && (int'($urandom_range(99)) >= gap_pct);
            dat[k] = (src[k].size() > 0) ? src[k][0] : 9'h000;
        end
        full = force_full || (full_pct > 0 && int'($urandom_range(99)) < full_pct);
        lvl  = rand_lvl ? 6'($urandom_range(40, 55)) : lvl_set;
    end

    // Compare process: outputs against the model, then advance the model.
    always @(negedge clk) begin
        logic [N-1:0] e_ready;
        logic [N-1:0] e_grant;
        cyc++;
        if (!rst_n) begin
            m_reset();
            hs_pend    = '0;
            prev_grant = '0;
            chk("reset_outputs",
                {o_grant, o_busy, o_fifo_wren, o_abort, o_abort_cnt, o_fifo_data, o_req_ready}, 32'd0);
        end else begin
            e_ready = '0;
            if (m_state == 1 && m_idle != TMO && !full) e_ready[m_owner] = 1'b1;
            e_grant = (m_state != 0) ? N'(1 << m_owner) : '0;
            chk("grant", 32'(o_grant), 32'(e_grant));
            chk("busy", 32'(o_busy), 32'(m_state != 0));
            chk("ready", 32'(o_req_ready), 32'(e_ready));
            chk("wren", 32'(o_fifo_wren), 32'(e_wren));
            chk("data", 32'(o_fifo_data), 32'(e_data));
            chk("abort", 32'(o_abort), 32'(e_abort));
            chk("abort_cnt", 32'(o_abort_cnt), 32'(m_abort_cnt));
            if (o_fifo_wren) begin
                wr_log.push_back(o_fifo_data);
                wr_cyc.push_back(cyc);
            end
            if (o_abort) abort_pulses++;
            if (prev_grant == '0 && o_grant != '0) begin
                for (int k = 0; k < N; k++) if (o_grant[k]) grant_log.push_back(k);
            end
            prev_grant = o_grant;
            hs_pend = vld & e_ready;
            m_step();
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_log.delete();
        wr_cyc.delete();
        grant_log.delete();
        abort_pulses = 0;
    endtask

    task automatic flush_src();
        for (int k = 0; k < N; k++) src[k].delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        flush_src();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic wait_idle(input int budget, input string nm);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            cyc_n(1);
            done = (m_state == 0);
            for (int k = 0; k < N; k++) if (src[k].size() != 0) done = 0;
        end
        chk(nm, 32'(done), 32'd1);
        cyc_n(3);
    endtask

    function automatic logic [8:0] rand_char();
        if ($urandom_range(9) == 0) return {1'b1, 7'($urandom_range(1, 127)), 1'($urandom)};
        return {1'b0, 8'($urandom)};
    endfunction

    task automatic load_rand_pkt(input int k);
        int len;
        len = int'($urandom_range(1, 6));
        for (int i = 0; i < len - 1; i++) src[k].push_back(rand_char());
        src[k].push_back(($urandom_range(3) == 0) ? 9'h101 : 9'h100);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] exp1 [4];
        logic [8:0] exp3 [6];
        logic [8:0] exp4 [5];
        int sz;
        exp1 = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h100};
        exp3 = '{9'h051, 9'h052, 9'h053, 9'h054, 9'h055, 9'h100};
        exp4 = '{9'h0B1, 9'h0B2, 9'h101, 9'h0C1, 9'h100};
        rst_n = 1'b0;
        vld   = '0;
        full  = 1'b0;
        lvl   = '0;
        for (int k = 0; k < N; k++) begin
            dat[k]  = '0;
            hold[k] = 0;
        end
        m_reset();
        clear_logs();
        #2;
        chk("por_grant", 32'(o_grant), 32'd0);
        chk("por_wren", 32'(o_fifo_wren), 32'd0);
        chk("por_abort_cnt", 32'(o_abort_cnt), 32'd0);
        do_reset();

        // Single packet from requester 0.
        cyc_n(1);
        foreach (exp1[i]) src[0].push_back(exp1[i]);
        cyc_n(1);
        chk("t1_grant_before", 32'(o_grant), 32'd0);
        cyc_n(1);
        chk("t1_grant_after", 32'(o_grant), 32'd1);
        wait_idle(50, "t1_done");
        chk("t1_wr_count", 32'(wr_log.size()), 32'd4);
        foreach (exp1[i]) chk("t1_wr_data", 32'(wr_log[i]), 32'(exp1[i]));
        chk("t1_busy_end", 32'(o_busy), 32'd0);

        // All requesters with one-character packets: strict rotation.
        do_reset();
        cyc_n(1);
        for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) src[k].push_back(9'h100);
        wait_idle(100, "t2_done");
        chk("t2_grant_count", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk("t2_grant_order", 32'(grant_log[i]), 32'(i % 4));
        chk("t2_wr_count", 32'(wr_log.size()), 32'd8);
        chk("t2_spacing", 32'(wr_cyc[7] - wr_cyc[0]), 32'd14);

        // Backpressure mid-packet is held, never timed out.
        do_reset();
        cyc_n(1);
        foreach (exp3[i]) src[1].push_back(exp3[i]);
        cyc_n(4);
        force_full = 1;
        cyc_n(3);
        sz = wr_log.size();
        chk("t3_ready_full", 32'(o_req_ready), 32'd0);
        cyc_n(17);
        chk("t3_no_write", 32'(wr_log.size()), 32'(sz));
        chk("t3_still_owner", 32'(o_grant), 32'd2);
        force_full = 0;
        wait_idle(50, "t3_done");
        chk("t3_wr_count", 32'(wr_log.size()), 32'd6);
        foreach (exp3[i]) chk("t3_wr_data", 32'(wr_log[i]), 32'(exp3[i]));
        chk("t3_no_abort", 32'(o_abort_cnt), 32'd0);

        // Start level gates new grants.
        do_reset();
        cyc_n(1);
        lvl_set = 6'd50;
        src[0].push_back(9'h100);
        cyc_n(6);
        chk("t5_no_grant", 32'(o_grant), 32'd0);
        lvl_set = 6'd47;
        cyc_n(1);
        chk("t5_grant_before", 32'(o_grant), 32'd0);
        cyc_n(1);
        chk("t5_grant_after", 32'(o_grant), 32'd1);
        wait_idle(50, "t5_done");
        lvl_set = 6'd0;

        // Stalled owner is cut off with EEP, next requester follows.
        do_reset();
        cyc_n(1);
        src[2].push_back(9'h0B1);
        src[2].push_back(9'h0B2);
        src[3].push_back(9'h0C1);
        src[3].push_back(9'h100);
        wait_idle(100, "t4_done");
        chk("t4_wr_count", 32'(wr_log.size()), 32'd5);
        foreach (exp4[i]) chk("t4_wr_data", 32'(wr_log[i]), 32'(exp4[i]));
        chk("t4_grants", 32'(grant_log.size()), 32'd2);
        chk("t4_grant0", 32'(grant_log[0]), 32'd2);
        chk("t4_grant1", 32'(grant_log[1]), 32'd3);
        chk("t4_abort_cnt", 32'(o_abort_cnt), 32'd1);
        chk("t4_abort_pulses", 32'(abort_pulses), 32'd1);

        // Reset while requester 3 owns the port.
        clear_logs();
        for (int i = 1; i <= 7; i++) src[3].push_back(9'(9'h0D0 + i));
        src[3].push_back(9'h100);
        cyc_n(5);
        chk("t6_owner3", 32'(o_grant), 32'd8);
        chk("t6_cnt_before", 32'(o_abort_cnt), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_grant_clr", 32'(o_grant), 32'd0);
        chk("t6_wren_clr", 32'(o_fifo_wren), 32'd0);
        chk("t6_cnt_clr", 32'(o_abort_cnt), 32'd0);
        flush_src();
        clear_logs();
        src[0].push_back(9'h100);
        src[1].push_back(9'h100);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        wait_idle(50, "t6_done");
        chk("t6_first_grant", 32'(grant_log[0]), 32'd0);
        chk("t6_second_grant", 32'(grant_log[1]), 32'd1);

        // Randomized traffic, backpressure, levels and stalls.
        do_reset();
        gap_pct  = 20;
        full_pct = 15;
        rand_lvl = 1;
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < N; k++) if (src[k].size() < 8) load_rand_pkt(k);
            if ($urandom_range(5) == 0) begin
                sz = int'($urandom_range(N - 1));
                hold[sz] = 1;
                cyc_n(15);
                hold[sz] = 0;
            end
            cyc_n(40);
        end
        gap_pct  = 0;
        full_pct = 0;
        rand_lvl = 0;
        lvl_set  = 6'd0;
        wait_idle(3000, "t7_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
